// File: rtl/btn_debounce_toggle_pkg.sv
`default_nettype none
// ============================================================================
// btn_pkg : shared state encoding and defaults for the button front end
// Revision 1.0
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } btn_state_e;

  localparam int   DEF_DEBOUNCE_CYCLES = 50000;
  localparam int   DEF_CNT_W           = 16;
  localparam logic LED_OFF             = 1'b1;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_toggle_if.sv
`default_nettype none
// ============================================================================
// btn_debounce_toggle_if : raw button inputs and debounced/LED outputs
// Revision 1.0
// ============================================================================
interface btn_debounce_toggle_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] i_btn_n;
  logic [N_BTN-1:0] o_btn_down;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_led_n;

  modport master (
    output i_btn_n,
    input  o_btn_down,
    input  o_press,
    input  o_release,
    input  o_led_n
  );

  modport slave (
    input  i_btn_n,
    output o_btn_down,
    output o_press,
    output o_release,
    output o_led_n
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce_toggle_ch.sv
`default_nettype none
// ============================================================================
// btn_debounce_ch : one channel - synchroniser, debounce FSM, pulses, LED toggle
// Revision 1.0
// ============================================================================
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  input  wire logic i_btn_n,
  output logic      o_btn_down,
  output logic      o_press,
  output logic      o_release,
  output logic      o_led_n
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             led_q, led_d;
  logic             w_s_btn_n;

  assign w_s_btn_n = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], i_btn_n};
    state_d   = state_q;
    cnt_d     = cnt_q;
    down_d    = down_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // LED follows the registered press pulse, so it flips one cycle later
    led_d     = press_q ? ~led_q : led_q;

    case (state_q)
      UP: begin
        if (!w_s_btn_n) begin
          state_d = WAIT_DN;
          cnt_d   = C_CNT_ONE;
        end
      end
      WAIT_DN: begin
        if (w_s_btn_n) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
          down_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      DOWN: begin
        if (w_s_btn_n) begin
          state_d = WAIT_UP;
          cnt_d   = C_CNT_ONE;
        end
      end
      WAIT_UP: begin
        if (!w_s_btn_n) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d   = UP;
          cnt_d     = '0;
          release_d = 1'b1;
          down_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q    <= 2'b11;
      state_q   <= UP;
      cnt_q     <= '0;
      down_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      led_q     <= LED_OFF;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      down_q    <= down_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_q     <= led_d;
    end
  end

  assign o_btn_down = down_q;
  assign o_press    = press_q;
  assign o_release  = release_q;
  assign o_led_n    = led_q;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_toggle.sv
`default_nettype none
// ============================================================================
// btn_debounce_toggle : N independent debounced button channels with LED toggle
// Revision 1.0
// ============================================================================
module btn_debounce_toggle
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  btn_debounce_toggle_if.slave  bus
);

  logic [N_BTN-1:0] w_btn_down;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_led_n;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_btn_n    (bus.i_btn_n[g]),
      .o_btn_down (w_btn_down[g]),
      .o_press    (w_press[g]),
      .o_release  (w_release[g]),
      .o_led_n    (w_led_n[g])
    );
  end

  assign bus.o_btn_down = w_btn_down;
  assign bus.o_press    = w_press;
  assign bus.o_release  = w_release;
  assign bus.o_led_n    = w_led_n;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_toggle.sv
`default_nettype none
// ============================================================================
// tb_btn_debounce_toggle : scoreboard bench for the button front end (DEB = 4)
// Revision 1.0
// ============================================================================
module tb_btn_debounce_toggle;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int CW  = 16;
  localparam int LAT = DEB + 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  ev_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  btn_debounce_toggle_if #(.N_BTN(N)) bus ();

  btn_debounce_toggle #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Every press/release pulse must match the oldest expected event exactly
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && ((bus.o_press | bus.o_release) !== 4'b0000)) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL pulse_unexpected cyc=%0d press=%b release=%b required no pulse",
                 cyc, bus.o_press, bus.o_release);
      end else begin
        e = q.pop_front();
        if (e.cyc !== cyc || e.press !== bus.o_press || e.rel !== bus.o_release)
          $display("FAIL pulse cyc=%0d press=%b release=%b required cyc=%0d press=%b release=%b",
                   cyc, bus.o_press, bus.o_release, e.cyc, e.press, e.rel);
        else
          n_pass++;
      end
    end
  end

  function automatic void push_ev(int c, logic [3:0] p, logic [3:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    q.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_btn_n = 4'b1111;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      n_chk++;
      if ({bus.o_btn_down, bus.o_press, bus.o_release, bus.o_led_n} !== 16'h000f)
        $display("FAIL reset_state cyc=%0d down=%b press=%b rel=%b led=%b required 0000 0000 0000 1111",
                 cyc, bus.o_btn_down, bus.o_press, bus.o_release, bus.o_led_n);
      else
        n_pass++;
    end
  endtask

  task automatic test_press0();
    int exp_c;
    bus.i_btn_n[0] = 1'b0;
    exp_c = cyc + 1 + LAT;
    push_ev(exp_c, 4'b0001, 4'b0000);
    wait_cyc(exp_c);
    n_chk++;
    if (bus.o_btn_down !== 4'b0001 || bus.o_led_n !== 4'b1111)
      $display("FAIL press0_edge down=%b led=%b required 0001 1111", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
    tick(1);
    n_chk++;
    if (bus.o_btn_down !== 4'b0001 || bus.o_led_n !== 4'b1110)
      $display("FAIL press0_led down=%b led=%b required 0001 1110", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
    tick(3);
  endtask

  task automatic test_bounce1();
    for (int k = 0; k < 30; k++) begin
      bus.i_btn_n[1] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    bus.i_btn_n[1] = 1'b1;
    tick(10);
    n_chk++;
    if (bus.o_btn_down !== 4'b0001 || bus.o_led_n !== 4'b1110)
      $display("FAIL bounce1 down=%b led=%b required 0001 1110", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      bus.i_btn_n[2] = 1'b0;
      push_ev(cyc + 1 + LAT, 4'b0100, 4'b0000);
      tick(10);
      n_chk++;
      if (bus.o_btn_down[2] !== 1'b1 || bus.o_led_n[2] !== ((i == 0) ? 1'b0 : 1'b1))
        $display("FAIL b2b_press%0d down2=%b led2=%b required 1 %b",
                 i, bus.o_btn_down[2], bus.o_led_n[2], (i == 0) ? 1'b0 : 1'b1);
      else
        n_pass++;
      bus.i_btn_n[2] = 1'b1;
      push_ev(cyc + 1 + LAT, 4'b0000, 4'b0100);
      tick(10);
    end
    n_chk++;
    if (bus.o_btn_down !== 4'b0001 || bus.o_led_n !== 4'b1110)
      $display("FAIL b2b_final down=%b led=%b required 0001 1110", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
  endtask

  task automatic test_simultaneous();
    int exp_c;
    bus.i_btn_n = 4'b1111;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    n_chk++;
    if (bus.o_btn_down !== 4'b0000 || bus.o_led_n !== 4'b1111)
      $display("FAIL sim_pre down=%b led=%b required 0000 1111", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
    bus.i_btn_n = 4'b0000;
    exp_c = cyc + 1 + LAT;
    push_ev(exp_c, 4'b1111, 4'b0000);
    wait_cyc(exp_c);
    n_chk++;
    if (bus.o_led_n !== 4'b1111)
      $display("FAIL sim_led_hold led=%b required 1111", bus.o_led_n);
    else
      n_pass++;
    tick(1);
    n_chk++;
    if (bus.o_btn_down !== 4'b1111 || bus.o_led_n !== 4'b0000)
      $display("FAIL sim_led down=%b led=%b required 1111 0000", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid();
    int exp_c;
    bus.i_btn_n = 4'b1111;
    push_ev(cyc + 1 + LAT, 4'b0000, 4'b1111);
    tick(10);
    n_chk++;
    if (bus.o_btn_down !== 4'b0000 || bus.o_led_n !== 4'b0000)
      $display("FAIL mid_pre down=%b led=%b required 0000 0000", bus.o_btn_down, bus.o_led_n);
    else
      n_pass++;
    // Reset lands on the edge where channel 3 would move from cnt 2 to 3
    bus.i_btn_n[3] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_chk++;
    if (bus.o_btn_down !== 4'b0000 || bus.o_led_n !== 4'b1111 || bus.o_press !== 4'b0000)
      $display("FAIL mid_reset down=%b led=%b press=%b required 0000 1111 0000",
               bus.o_btn_down, bus.o_led_n, bus.o_press);
    else
      n_pass++;
    exp_c = cyc + 1 + LAT;
    push_ev(exp_c, 4'b1000, 4'b0000);
    wait_cyc(exp_c);
    n_chk++;
    if (bus.o_btn_down !== 4'b1000)
      $display("FAIL mid_reaccept down=%b required 1000", bus.o_btn_down);
    else
      n_pass++;
    tick(1);
    n_chk++;
    if (bus.o_led_n !== 4'b0111)
      $display("FAIL mid_led led=%b required 0111", bus.o_led_n);
    else
      n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_btn_n = 4'b1111;
    test_reset();
    test_press0();
    test_bounce1();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    tick(10);
    n_chk++;
    if (q.size() != 0)
      $display("FAIL missing_pulses pending=%0d required 0", q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d required completion", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
